// File: rtl/systolic_act_skew_feeder.sv
// Activation feeder for one edge of the systolic array: buffers input vectors in a
// small FIFO and emits them diagonally skewed, lane r delayed r cycles behind lane 0.
module systolic_act_skew_feeder #(
  parameter int BW_ACT     = 8,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*BW_ACT-1:0] in_act,
  input  logic                   in_last,
  output logic [ROWS*BW_ACT-1:0] out_act,
  output logic [ROWS-1:0]        out_mac_enable,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = ROWS*BW_ACT + 1;
  localparam int CW = $clog2(ROWS);

  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ROWS-1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e          state_q;
  logic [CW-1:0]   drain_cnt_q;
  logic            done_q;

  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic [AW:0]     wr_ptr_d;
  logic [AW:0]     rd_ptr_d;

  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic [DW-1:0]   rd_data;
  logic            pop_last;
  logic [DW-2:0]   pop_act;

  // The extra wrap bit tells full (MSBs differ) apart from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full && !flush;
  assign pop      = (state_q == STREAM) && !fifo_empty && !flush;

  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_last = rd_data[DW-1];
  assign pop_act  = rd_data[DW-2:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_act};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) state_q <= STREAM;
        end
        STREAM: begin
          if (pop && pop_last) begin
            state_q     <= DRAIN;
            drain_cnt_q <= CNT_INIT;
          end
        end
        DRAIN: begin
          // Done lands on the edge where the last vector reaches the far lane.
          if (drain_cnt_q == CNT_ONE) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            done_q      <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  for (genvar r = 0; r < ROWS; r++) begin : lane_g
    logic [BW_ACT-1:0] dat_q [r+1];
    logic              en_q  [r+1];

    // Every lane captures the pop at stage 0; lane r then walks r more stages.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s <= r; s++) begin
          dat_q[s] <= '0;
          en_q[s]  <= 1'b0;
        end
      end else if (flush) begin
        for (int s = 0; s <= r; s++) begin
          dat_q[s] <= '0;
          en_q[s]  <= 1'b0;
        end
      end else begin
        dat_q[0] <= pop ? pop_act[r*BW_ACT +: BW_ACT] : '0;
        en_q[0]  <= pop;
        for (int s = 1; s <= r; s++) begin
          dat_q[s] <= dat_q[s-1];
          en_q[s]  <= en_q[s-1];
        end
      end
    end

    assign out_act[r*BW_ACT +: BW_ACT] = dat_q[r];
    assign out_mac_enable[r]           = en_q[r];
  end

endmodule

// File: tb/tb_systolic_act_skew_feeder.sv
// Directed bench for systolic_act_skew_feeder: a table-driven tile plus hand
// sequences for async reset, starvation, back-pressure, pointer wrap and flush.
module tb_systolic_act_skew_feeder;

  localparam int BW_ACT     = 8;
  localparam int ROWS       = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int W          = ROWS*BW_ACT;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_act;
  logic            in_last;
  logic [W-1:0]    out_act;
  logic [ROWS-1:0] out_mac_enable;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;

  systolic_act_skew_feeder #(
    .BW_ACT(BW_ACT), .ROWS(ROWS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_last(in_last),
    .out_act(out_act), .out_mac_enable(out_mac_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            fl;
    logic            st;
    logic            vld;
    logic            lst;
    logic [W-1:0]    act;
    logic [W-1:0]    expAct;
    logic [ROWS-1:0] expEn;
    logic            expReady;
    logic            expBusy;
    logic            expDone;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(input logic fl, st, vld, lst, input logic [W-1:0] act,
                              input logic [W-1:0] eAct, input logic [ROWS-1:0] eEn,
                              input logic eReady, eBusy, eDone);
    vec_t v;
    v.fl = fl; v.st = st; v.vld = vld; v.lst = lst; v.act = act;
    v.expAct = eAct; v.expEn = eEn; v.expReady = eReady; v.expBusy = eBusy; v.expDone = eDone;
    return v;
  endfunction

  // Drives one cycle of inputs, then lands 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic fl, st, vld, lst, input logic [W-1:0] act);
    flush = fl; start = st; in_valid = vld; in_last = lst; in_act = act;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] eAct,
                             input logic [ROWS-1:0] eEn, input logic eReady, eBusy, eDone);
    total++;
    if (out_act !== eAct || out_mac_enable !== eEn || in_ready !== eReady ||
        busy !== eBusy || done !== eDone) begin
      bad++;
      $display("[TB] FAIL %s: got act=%h en=%b ready=%b busy=%b done=%b, want act=%h en=%b ready=%b busy=%b done=%b",
               name, out_act, out_mac_enable, in_ready, busy, done,
               eAct, eEn, eReady, eBusy, eDone);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [W-1:0] wrapVec(input int i);
    logic [7:0] l0, l1, l2, l3;
    l0 = 8'(i);
    l1 = 8'(8'h40 + i);
    l2 = 8'(8'h80 + i);
    l3 = (i == 19) ? 8'hF7 : 8'(8'hC0 + i);
    return {l3, l2, l1, l0};
  endfunction

  initial begin
    int cnt;
    int n0;
    int n3;
    int pushed;
    logic doneSeen;
    logic [7:0] lastLane3;
    logic [W-1:0] wv;

    tbl[0]  = mk(0,0,1,0,32'h04030201, 32'h00000000, 4'b0000, 1,0,0);
    tbl[1]  = mk(0,0,1,0,32'h14131211, 32'h00000000, 4'b0000, 1,0,0);
    tbl[2]  = mk(0,0,1,1,32'h24232221, 32'h00000000, 4'b0000, 1,0,0);
    tbl[3]  = mk(0,1,0,0,32'h0,        32'h00000000, 4'b0000, 1,1,0);
    tbl[4]  = mk(0,0,0,0,32'h0,        32'h00000001, 4'b0001, 1,1,0);
    tbl[5]  = mk(0,0,0,0,32'h0,        32'h00000211, 4'b0011, 1,1,0);
    tbl[6]  = mk(0,0,0,0,32'h0,        32'h00031221, 4'b0111, 1,1,0);
    tbl[7]  = mk(0,0,0,0,32'h0,        32'h04132200, 4'b1110, 1,1,0);
    tbl[8]  = mk(0,0,0,0,32'h0,        32'h14230000, 4'b1100, 1,1,0);
    tbl[9]  = mk(0,0,0,0,32'h0,        32'h24000000, 4'b1000, 1,0,1);
    tbl[10] = mk(0,0,0,0,32'h0,        32'h00000000, 4'b0000, 1,0,0);

    reset_n = 1'b0; flush = 0; start = 0; in_valid = 0; in_last = 0; in_act = '0;
    #12;
    checkOutput("reset", '0, '0, 1, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single tile");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].fl, tbl[i].st, tbl[i].vld, tbl[i].lst, tbl[i].act);
      checkOutput($sformatf("tile[%0d]", i), tbl[i].expAct, tbl[i].expEn,
                  tbl[i].expReady, tbl[i].expBusy, tbl[i].expDone);
    end

    $display("[TB] async reset mid-stream");
    applyStimulus(0,0,1,0,32'h0A0B0C0D);
    applyStimulus(0,0,1,0,32'h1A1B1C1D);
    applyStimulus(0,1,0,0,'0);
    applyStimulus(0,0,0,0,'0);
    checkOutput("pre-reset stream", 32'h0000000D, 4'b0001, 1, 1, 0);
    #2 reset_n = 1'b0;
    #1 checkOutput("async reset", '0, '0, 1, 0, 0);
    #1 reset_n = 1'b1;
    applyStimulus(0,0,0,0,'0);
    checkOutput("idle after reset", '0, '0, 1, 0, 0);

    $display("[TB] starvation");
    applyStimulus(0,1,0,0,'0);
    checkOutput("starve start", '0, '0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0,0,0,0,'0);
      checkOutput($sformatf("starve bubble[%0d]", i), '0, '0, 1, 1, 0);
    end
    applyStimulus(0,0,1,1,32'hA4A3A2A1);
    checkOutput("starve push", '0, '0, 1, 1, 0);
    applyStimulus(0,0,0,0,'0);
    checkOutput("starve lane0", 32'h000000A1, 4'b0001, 1, 1, 0);
    applyStimulus(0,0,0,0,'0);
    checkOutput("starve lane1", 32'h0000A200, 4'b0010, 1, 1, 0);
    applyStimulus(0,0,0,0,'0);
    checkOutput("starve lane2", 32'h00A30000, 4'b0100, 1, 1, 0);
    applyStimulus(0,0,0,0,'0);
    checkOutput("starve lane3 done", 32'hA4000000, 4'b1000, 1, 0, 1);
    applyStimulus(0,0,0,0,'0);
    checkOutput("starve idle", '0, '0, 1, 0, 0);

    $display("[TB] full and back-pressure");
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      applyStimulus(0, 0, 1, (i == FIFO_DEPTH-1), 32'h01010101 * (i+1));
      checkValue($sformatf("ready after push %0d", i), 32'(in_ready), 32'((i < FIFO_DEPTH-1) ? 1 : 0));
    end
    applyStimulus(0,0,1,0,32'hEEEEEEEE);
    checkValue("ready after 9th valid", 32'(in_ready), 32'd0);
    applyStimulus(0,1,0,0,'0);
    checkOutput("full start", '0, '0, 0, 1, 0);
    applyStimulus(0,0,0,0,'0);
    checkOutput("first pop frees slot", 32'h00000001, 4'b0001, 1, 1, 0);
    cnt = 1;
    doneSeen = 1'b0;
    for (int c = 0; c < 20 && !doneSeen; c++) begin
      applyStimulus(0,0,0,0,'0);
      if (out_mac_enable[0]) begin
        cnt++;
        checkValue($sformatf("full lane0 #%0d", cnt), 32'(out_act[7:0]), 32'(cnt));
      end
      if (done) doneSeen = 1'b1;
    end
    checkValue("full done seen", 32'(doneSeen), 32'd1);
    checkValue("full pop count", 32'(cnt), 32'(FIFO_DEPTH));
    applyStimulus(0,1,0,0,'0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0,0,0,0,'0);
      checkOutput($sformatf("9th dropped[%0d]", i), '0, '0, 1, 1, 0);
    end
    applyStimulus(1,0,0,0,'0);

    $display("[TB] pointer wrap");
    applyStimulus(0,1,0,0,'0);
    pushed = 0; n0 = 0; n3 = 0; doneSeen = 1'b0; lastLane3 = '0;
    for (int c = 0; c < 60 && !doneSeen; c++) begin
      if (pushed < 20) begin
        wv = wrapVec(pushed);
        if (in_ready) begin
          applyStimulus(0, 0, 1, (pushed == 19), wv);
          pushed++;
        end else begin
          applyStimulus(0, 0, 0, 0, '0);
        end
      end else begin
        applyStimulus(0, 0, 0, 0, '0);
      end
      if (out_mac_enable[0]) begin
        wv = wrapVec(n0);
        checkValue($sformatf("wrap lane0 #%0d", n0), 32'(out_act[7:0]), 32'(wv[7:0]));
        n0++;
      end
      if (out_mac_enable[3]) begin
        wv = wrapVec(n3);
        checkValue($sformatf("wrap lane3 #%0d", n3), 32'(out_act[31:24]), 32'(wv[31:24]));
        lastLane3 = out_act[31:24];
        n3++;
      end
      if (done) doneSeen = 1'b1;
    end
    checkValue("wrap done seen", 32'(doneSeen), 32'd1);
    checkValue("wrap lane0 count", 32'(n0), 32'd20);
    checkValue("wrap lane3 count", 32'(n3), 32'd20);
    checkValue("wrap signed last", 32'(lastLane3), 32'h000000F7);

    $display("[TB] flush mid-tile");
    applyStimulus(0,0,0,0,'0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 32'h55555555 + i);
    applyStimulus(0,1,0,0,'0);
    checkOutput("flush pre", '0, '0, 1, 1, 0);
    applyStimulus(1,0,1,1,32'h66666666);
    checkOutput("flush clears", '0, '0, 1, 0, 0);
    applyStimulus(0,1,0,0,'0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0,0,0,0,'0);
      checkOutput($sformatf("flush empty[%0d]", i), '0, '0, 1, 1, 0);
    end
    applyStimulus(1,0,0,0,'0);
    checkOutput("final idle", '0, '0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_act_skew_feeder.md
Name: systolic_act_skew_feeder

Overview:
- Upstream feeder for one column edge of the systolic PE array.
- Accepts one activation vector per handshake, with one BW_ACT lane per array row, and buffers vectors in a small FIFO.
- Emits the vectors diagonally skewed: lane r is delayed r cycles relative to lane 0. Each lane drives the act input of row r, and a matching per-row MAC enable travels with the data.
- A start/last/done sequence lets the controller frame one matrix tile.

Parameters:
- BW_ACT, 8, bit width of one activation lane (signed).
- ROWS, 4, number of array rows / lanes (>=2).
- FIFO_DEPTH, 8, input FIFO depth in vectors (power of 2, >=2).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of FIFO, skew pipeline and FSM; priority over all other inputs.
- start  input  1  one-cycle pulse; begins a tile when in IDLE, ignored otherwise.
- in_valid  input  1  input vector valid.
- in_ready  output  1  FIFO can accept; equals !fifo_full.
- in_act  input  ROWS*BW_ACT  input vector; lane r = bits [r*BW_ACT +: BW_ACT].
- in_last  input  1  marks final vector of the tile; stored in FIFO alongside data.
- out_act  output  ROWS*BW_ACT  skewed activations; lane r feeds PE row r.
- out_mac_enable  output  ROWS  per-row MAC enable, skewed identically to data.
- busy  output  1  high in STREAM or DRAIN.
- done  output  1  one-cycle pulse at end of drain.

Behaviour:
- Reset (async, reset_n=0): FIFO empty, all skew registers 0, out_act=0, out_mac_enable=0, busy=0, done=0, FSM=IDLE, in_ready=1.
- FIFO write:
  - Occurs when in_valid && in_ready, in any FSM state.
  - Width is ROWS*BW_ACT+1, with the last flag included.
  - Read/write pointers wrap modulo FIFO_DEPTH and carry an extra wrap bit for full/empty.
  - Simultaneous push and pop when full is not allowed, because in_ready=0 blocks the push. Simultaneous push and pop when neither full nor empty leaves the count unchanged.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: no pops. start -> STREAM. The FIFO may fill while in IDLE.
  - STREAM: pop one vector per cycle whenever the FIFO is non-empty. A popped vector with last=1 -> DRAIN, with drain counter = ROWS-1. If the FIFO is empty, no pop happens and a bubble enters lane 0 (enable 0, data 0). This is not an error.
  - DRAIN: no pops. The counter decrements each cycle. When the counter reaches 0 at a clock edge, assert done for one cycle and go to IDLE. A start pulse in that same cycle is ignored.
- Skew pipeline:
  - Lane 0 has a single register stage. Lane r has r+1 stages.
  - Lane 0 register loads the popped data with enable=1 on the pop edge, or 0/0 on a bubble.
  - Data and enable of lane r appear r cycles after lane 0 (latency start-of-pop to lane r = r+1 edges).
  - All skew registers keep shifting in every state, with zero/0 injected when not popping, so DRAIN flushes the last vector out.
- Timing of done: the cycle after done, the last vector's lane ROWS-1 enable has just been presented. out_mac_enable is 0 in all lanes in IDLE after a completed tile.
- busy = (state != IDLE).
- flush:
  - Next edge: pointers reset, skew registers and outputs 0, FSM to IDLE, done=0.
  - A push in the same cycle as flush is dropped.
- No arithmetic is performed; data is passed through bit-exact. Signed values are not sign-modified.

Test Plan:
- Reset mid-STREAM with ROWS=4: assert reset_n=0 -> out_act=0, out_mac_enable=4'b0000, in_ready=1, busy=0 immediately (async). After release, state is IDLE.
- Single tile:
  - Stimulus: push 3 vectors {lane3..0} = {04,03,02,01}, {14,13,12,11}, {24,23,22,21} (last on third), then pulse start.
  - Lane 0 shows 01, 11, 21 on consecutive cycles with enable 1. Lane 3 shows 04, 14, 24 three cycles later.
  - done pulses once, ROWS-1=3 cycles after the last pop, then busy=0.
- Starvation:
  - Stimulus: start with FIFO empty, then push one vector (last=1) 5 cycles later.
  - Response: out_mac_enable stays 0 for those 5 cycles, then the vector appears skewed and done follows.
- Full/back-pressure:
  - Stimulus: in IDLE, push FIFO_DEPTH=8 vectors.
  - Response: in_ready=0 after the 8th push; a 9th in_valid is not accepted. After start, in_ready returns to 1 one cycle after the first pop.
- Pointer wrap: stream 20 vectors with continuous in_valid during STREAM -> all 20 emerge in order with no loss or duplication; the last vector's lane 3 value is 0xF7 when pushed as 0xF7 (signed -9 preserved).
- Flush mid-tile: flush during STREAM with 4 vectors queued -> next cycle FIFO empty, out_mac_enable=0, busy=0, no done pulse.
